// File: rtl/bram_path_read_scheduler_pkg.sv
// Shared types and constants for the BRAM path read scheduler.
package bram_path_read_scheduler_pkg;

  // Width of the path index; the number of paths is 2^SEG_BITS.
  localparam int SEG_BITS   = 4;
  localparam int NP         = 1 << SEG_BITS;
  // Default BRAM read latency (legal range 1..4).
  localparam int RD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One slot of the read-latency pipeline.
  typedef struct packed {
    logic                vld;
    logic [SEG_BITS-1:0] seg;
  } rd_tag_t;

  // One-hot path mask for a path index.
  function automatic logic [NP-1:0] seg_onehot(input logic [SEG_BITS-1:0] seg);
    return {{(NP-1){1'b0}}, 1'b1} << seg;
  endfunction

endpackage

// File: rtl/bram_path_read_scheduler_rr_arbiter_np.sv
// NP-wide round-robin arbiter. Grants the lowest eligible index at or above
// the pointer, otherwise wraps to the lowest eligible index. The pointer
// moves to grant+1 only when the caller accepts the grant (adv).
module rr_arbiter_np
  import bram_path_read_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                rst_b,
  input  logic [NP-1:0]       elig,
  input  logic                adv,
  output logic                grant_vld,
  output logic [SEG_BITS-1:0] grant_idx
);

  logic [SEG_BITS-1:0] r_ptr;
  logic                w_hi_vld;
  logic [SEG_BITS-1:0] w_hi_idx;
  logic                w_lo_vld;
  logic [SEG_BITS-1:0] w_lo_idx;

  // Priority search: scanning downward leaves the lowest match in each set.
  always_comb begin
    w_hi_vld = 1'b0;
    w_hi_idx = {SEG_BITS{1'b0}};
    w_lo_vld = 1'b0;
    w_lo_idx = {SEG_BITS{1'b0}};
    for (int i = NP - 1; i >= 0; i--) begin
      w_lo_vld = w_lo_vld | elig[i];
      w_lo_idx = elig[i] ? SEG_BITS'(i) : w_lo_idx;
      w_hi_vld = w_hi_vld | (elig[i] && (SEG_BITS'(i) >= r_ptr));
      w_hi_idx = (elig[i] && (SEG_BITS'(i) >= r_ptr)) ? SEG_BITS'(i) : w_hi_idx;
    end
  end

  assign grant_vld = w_lo_vld;
  assign grant_idx = w_hi_vld ? w_hi_idx : w_lo_idx;

  // Pointer advances past the granted path only on an accepted grant.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_ptr <= {SEG_BITS{1'b0}};
    end else if (adv && grant_vld) begin
      r_ptr <= grant_idx + {{(SEG_BITS-1){1'b0}}, 1'b1};
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/bram_path_read_scheduler.sv
// Schedules BRAM reads for the slow merge-tree stages: arbitrates path refill
// requests, issues one path read per cycle to the read-enable decoder, tracks
// reads through the fixed BRAM latency and tags the returning data.
module bram_path_read_scheduler
  import bram_path_read_scheduler_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                start,
  input  logic                stop,
  input  logic [NP-1:0]       req,
  input  logic                stall,
  output logic                decode_en_blk,
  output logic [SEG_BITS-1:0] addr_seg,
  output logic                rd_vld,
  output logic [SEG_BITS-1:0] rd_seg,
  output logic [NP-1:0]       inflight,
  output logic                busy,
  output logic                done
);

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_decode_en;
  logic [SEG_BITS-1:0] r_addr_seg;
  logic                r_rd_vld;
  logic [SEG_BITS-1:0] r_rd_seg;
  logic [NP-1:0]       r_inflight;
  rd_tag_t             r_pipe [RD_LAT];

  logic [NP-1:0]       w_elig;
  logic                w_grant_vld;
  logic [SEG_BITS-1:0] w_grant_idx;
  logic                w_issue;
  rd_tag_t             w_issue_tag;
  rd_tag_t             w_ret_tag;
  logic [NP-1:0]       w_set_mask;
  logic [NP-1:0]       w_clr_mask;
  logic                w_pipe_busy;

  // A path with an outstanding read is never offered to the arbiter again.
  assign w_elig  = req & ~r_inflight;
  // stop in the same cycle wins over a would-be issue.
  assign w_issue = (r_state == RUN) && !stall && w_grant_vld && !stop;

  rr_arbiter_np u_arb (
    .clk       (clk),
    .rst_b     (rst_b),
    .elig      (w_elig),
    .adv       (w_issue),
    .grant_vld (w_grant_vld),
    .grant_idx (w_grant_idx)
  );

  assign w_issue_tag = {w_issue, (w_issue ? w_grant_idx : {SEG_BITS{1'b0}})};
  assign w_ret_tag   = r_pipe[RD_LAT-1];
  assign w_set_mask  = w_issue ? seg_onehot(w_grant_idx) : {NP{1'b0}};
  assign w_clr_mask  = w_ret_tag.vld ? seg_onehot(w_ret_tag.seg) : {NP{1'b0}};

  // Any read still travelling through the latency pipeline.
  always_comb begin
    w_pipe_busy = 1'b0;
    for (int k = 0; k < RD_LAT; k++) begin
      w_pipe_busy = w_pipe_busy | r_pipe[k].vld;
    end
  end

  // Control FSM: IDLE -> RUN on start, RUN -> DRAIN on stop, DRAIN -> IDLE
  // once every outstanding read has returned.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          r_done <= 1'b0;
          r_busy <= 1'b1;
          if (stop) begin
            r_state <= DRAIN;
          end else begin
            r_state <= RUN;
          end
        end
        DRAIN: begin
          if ((r_inflight == {NP{1'b0}}) && !w_pipe_busy) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= DRAIN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Issue register, latency pipeline, return tagging and in-flight tracking.
  // The return clears its in-flight bit at the same edge rd_vld is raised,
  // so the path is eligible during the rd_vld cycle.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_decode_en <= 1'b0;
      r_addr_seg  <= {SEG_BITS{1'b0}};
      r_rd_vld    <= 1'b0;
      r_rd_seg    <= {SEG_BITS{1'b0}};
      r_inflight  <= {NP{1'b0}};
      for (int k = 0; k < RD_LAT; k++) begin
        r_pipe[k] <= '0;
      end
    end else begin
      r_decode_en <= w_issue;
      r_addr_seg  <= w_issue_tag.seg;
      r_pipe[0]   <= w_issue_tag;
      for (int k = 1; k < RD_LAT; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
      r_rd_vld    <= w_ret_tag.vld;
      r_rd_seg    <= w_ret_tag.vld ? w_ret_tag.seg : {SEG_BITS{1'b0}};
      r_inflight  <= (r_inflight & ~w_clr_mask) | w_set_mask;
    end
  end

  assign decode_en_blk = r_decode_en;
  assign addr_seg      = r_addr_seg;
  assign rd_vld        = r_rd_vld;
  assign rd_seg        = r_rd_seg;
  assign inflight      = r_inflight;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_bram_path_read_scheduler.sv
// Directed, table-driven bench for bram_path_read_scheduler (SEG_BITS=4, RD_LAT=2).
module tb_bram_path_read_scheduler;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start;
  logic        stop;
  logic [15:0] req;
  logic        stall;
  logic        decode_en_blk;
  logic [3:0]  addr_seg;
  logic        rd_vld;
  logic [3:0]  rd_seg;
  logic [15:0] inflight;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  bram_path_read_scheduler dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .start         (start),
    .stop          (stop),
    .req           (req),
    .stall         (stall),
    .decode_en_blk (decode_en_blk),
    .addr_seg      (addr_seg),
    .rd_vld        (rd_vld),
    .rd_seg        (rd_seg),
    .inflight      (inflight),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Output bundle: {decode_en_blk, addr_seg, rd_vld, rd_seg, inflight, busy, done}
  logic [27:0] act;
  assign act = {decode_en_blk, addr_seg, rd_vld, rd_seg, inflight, busy, done};

  typedef struct {
    logic        start;
    logic        stop;
    logic        stall;
    logic [15:0] req;
    logic [27:0] exp;
  } vec_t;

  vec_t vecs [31];

  function automatic logic [27:0] pk(input logic de, input logic [3:0] as,
                                     input logic rv, input logic [3:0] rs,
                                     input logic [15:0] inf, input logic bz,
                                     input logic dn);
    return {de, as, rv, rs, inf, bz, dn};
  endfunction

  function automatic vec_t mv(input logic st, input logic sp, input logic sl,
                              input logic [15:0] rq, input logic [27:0] ex);
    vec_t v;
    v.start = st;
    v.stop  = sp;
    v.stall = sl;
    v.req   = rq;
    v.exp   = ex;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, got, want);
    end
  endtask

  // Watchdog: every wait below is a fixed number of cycles, this only guards
  // against a broken clock.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e_as;

    //            start stop stall req       de as  rv rs  inflight  busy done
    vecs[0]  = mv(1'b1, 1'b0, 1'b0, 16'h0001, pk(1'b0, 4'd0,  1'b0, 4'd0,  16'h0000, 1'b1, 1'b0));
    vecs[1]  = mv(1'b0, 1'b0, 1'b0, 16'h0001, pk(1'b1, 4'd0,  1'b0, 4'd0,  16'h0001, 1'b1, 1'b0));
    vecs[2]  = mv(1'b0, 1'b0, 1'b0, 16'h0001, pk(1'b0, 4'd0,  1'b0, 4'd0,  16'h0001, 1'b1, 1'b0));
    vecs[3]  = mv(1'b0, 1'b0, 1'b0, 16'h0001, pk(1'b0, 4'd0,  1'b1, 4'd0,  16'h0000, 1'b1, 1'b0));
    vecs[4]  = mv(1'b0, 1'b0, 1'b0, 16'h0001, pk(1'b1, 4'd0,  1'b0, 4'd0,  16'h0001, 1'b1, 1'b0));
    vecs[5]  = mv(1'b0, 1'b0, 1'b0, 16'h0001, pk(1'b0, 4'd0,  1'b0, 4'd0,  16'h0001, 1'b1, 1'b0));
    vecs[6]  = mv(1'b0, 1'b0, 1'b0, 16'h0001, pk(1'b0, 4'd0,  1'b1, 4'd0,  16'h0000, 1'b1, 1'b0));
    vecs[7]  = mv(1'b0, 1'b1, 1'b0, 16'h0001, pk(1'b0, 4'd0,  1'b0, 4'd0,  16'h0000, 1'b1, 1'b0));
    vecs[8]  = mv(1'b0, 1'b0, 1'b0, 16'h0001, pk(1'b0, 4'd0,  1'b0, 4'd0,  16'h0000, 1'b0, 1'b1));
    vecs[9]  = mv(1'b0, 1'b1, 1'b0, 16'h0001, pk(1'b0, 4'd0,  1'b0, 4'd0,  16'h0000, 1'b0, 1'b0));
    vecs[10] = mv(1'b1, 1'b0, 1'b0, 16'h0000, pk(1'b0, 4'd0,  1'b0, 4'd0,  16'h0000, 1'b1, 1'b0));
    vecs[11] = mv(1'b0, 1'b0, 1'b0, 16'h0008, pk(1'b1, 4'd3,  1'b0, 4'd0,  16'h0008, 1'b1, 1'b0));
    vecs[12] = mv(1'b0, 1'b0, 1'b0, 16'h8009, pk(1'b1, 4'd15, 1'b0, 4'd0,  16'h8008, 1'b1, 1'b0));
    vecs[13] = mv(1'b0, 1'b0, 1'b0, 16'h8009, pk(1'b1, 4'd0,  1'b1, 4'd3,  16'h8001, 1'b1, 1'b0));
    vecs[14] = mv(1'b0, 1'b0, 1'b0, 16'h8009, pk(1'b1, 4'd3,  1'b1, 4'd15, 16'h0009, 1'b1, 1'b0));
    vecs[15] = mv(1'b0, 1'b0, 1'b0, 16'h0000, pk(1'b0, 4'd0,  1'b1, 4'd0,  16'h0008, 1'b1, 1'b0));
    vecs[16] = mv(1'b0, 1'b0, 1'b0, 16'h0000, pk(1'b0, 4'd0,  1'b1, 4'd3,  16'h0000, 1'b1, 1'b0));
    vecs[17] = mv(1'b0, 1'b0, 1'b0, 16'h0000, pk(1'b0, 4'd0,  1'b0, 4'd0,  16'h0000, 1'b1, 1'b0));
    vecs[18] = mv(1'b0, 1'b0, 1'b0, 16'h0006, pk(1'b1, 4'd1,  1'b0, 4'd0,  16'h0002, 1'b1, 1'b0));
    vecs[19] = mv(1'b0, 1'b0, 1'b0, 16'h0006, pk(1'b1, 4'd2,  1'b0, 4'd0,  16'h0006, 1'b1, 1'b0));
    vecs[20] = mv(1'b0, 1'b0, 1'b1, 16'h0006, pk(1'b0, 4'd0,  1'b1, 4'd1,  16'h0004, 1'b1, 1'b0));
    vecs[21] = mv(1'b0, 1'b0, 1'b1, 16'h0006, pk(1'b0, 4'd0,  1'b1, 4'd2,  16'h0000, 1'b1, 1'b0));
    vecs[22] = mv(1'b0, 1'b0, 1'b1, 16'h0006, pk(1'b0, 4'd0,  1'b0, 4'd0,  16'h0000, 1'b1, 1'b0));
    vecs[23] = mv(1'b0, 1'b0, 1'b1, 16'h0006, pk(1'b0, 4'd0,  1'b0, 4'd0,  16'h0000, 1'b1, 1'b0));
    vecs[24] = mv(1'b0, 1'b0, 1'b1, 16'h0006, pk(1'b0, 4'd0,  1'b0, 4'd0,  16'h0000, 1'b1, 1'b0));
    vecs[25] = mv(1'b0, 1'b0, 1'b0, 16'h0006, pk(1'b1, 4'd1,  1'b0, 4'd0,  16'h0002, 1'b1, 1'b0));
    vecs[26] = mv(1'b0, 1'b0, 1'b0, 16'h0006, pk(1'b1, 4'd2,  1'b0, 4'd0,  16'h0006, 1'b1, 1'b0));
    vecs[27] = mv(1'b0, 1'b1, 1'b0, 16'h0006, pk(1'b0, 4'd0,  1'b1, 4'd1,  16'h0004, 1'b1, 1'b0));
    vecs[28] = mv(1'b1, 1'b0, 1'b0, 16'h0006, pk(1'b0, 4'd0,  1'b1, 4'd2,  16'h0000, 1'b1, 1'b0));
    vecs[29] = mv(1'b0, 1'b0, 1'b0, 16'h0006, pk(1'b0, 4'd0,  1'b0, 4'd0,  16'h0000, 1'b0, 1'b1));
    vecs[30] = mv(1'b0, 1'b0, 1'b0, 16'h0006, pk(1'b0, 4'd0,  1'b0, 4'd0,  16'h0000, 1'b0, 1'b0));

    // Reset state
    rst_b = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    stall = 1'b0;
    req   = 16'h0000;
    step();
    step();
    chk("reset", 0, {4'd0, act}, 32'd0);
    rst_b = 1'b1;

    // Table: inputs applied for one cycle, outputs compared after that edge
    for (int i = 0; i < 31; i++) begin
      start = vecs[i].start;
      stop  = vecs[i].stop;
      stall = vecs[i].stall;
      req   = vecs[i].req;
      step();
      chk("vec", i, {4'd0, act}, {4'd0, vecs[i].exp});
    end

    // All paths requesting from a fresh pointer: 0..15 then wrap to 0
    start = 1'b0;
    stop  = 1'b0;
    stall = 1'b0;
    req   = 16'h0000;
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    start = 1'b1;
    req   = 16'hFFFF;
    step();
    chk("wrap_start", 0, {31'd0, decode_en_blk}, 32'd0);
    start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      e_as = 4'(n % 16);
      chk("wrap_seq", n, {27'd0, decode_en_blk, addr_seg}, {27'd0, 1'b1, e_as});
    end

    // Reset mid-RUN with reads in flight: everything clears, no late returns
    rst_b = 1'b0;
    req   = 16'h0000;
    step();
    chk("rst_mid", 0, {4'd0, act}, 32'd0);
    rst_b = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("post_rst", n, {4'd0, act}, 32'd0);
    end

    // Pointer was cleared by the reset: 8001 must grant path 0, not 15
    start = 1'b1;
    req   = 16'h8001;
    step();
    chk("ptr_rst_a", 0, {4'd0, act}, {4'd0, pk(1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0)});
    start = 1'b0;
    step();
    chk("ptr_rst_b", 0, {4'd0, act}, {4'd0, pk(1'b1, 4'd0, 1'b0, 4'd0, 16'h0001, 1'b1, 1'b0)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_path_read_scheduler.md
Name: bram_path_read_scheduler

Overview:
- Sequences reads of the slow (BRAM-backed) merge-tree stages.
- Each of the 2^SEG_BITS root-to-leaf paths raises a refill request. The block round-robin arbitrates among them and drives the path read-enable decoder with one path per cycle (decode_en_blk, addr_seg).
- It tracks in-flight reads through the fixed BRAM read latency and tags returned data with its path. A path is never re-issued while a read for it is still in flight.
- Sits between the slow-stage FIFO refill logic and the BRAM read-enable decoder.

Parameters:
- SEG_BITS, 4, width of addr_seg; number of paths NP = 2^SEG_BITS (equals NUM_STGs - END_OF_FAST_STG).
- RD_LAT, 2, cycles from a read-enable issue to BRAM data valid (legal range 1..4).

Ports:
- clk  in  1  system clock
- rst_b  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; IDLE -> RUN
- stop  in  1  one-cycle pulse; RUN -> DRAIN
- req  in  NP  per-path refill request, level-sensitive, bit i = path i
- stall  in  1  downstream back-pressure; suppresses new issue only
- decode_en_blk  out  1  read enable to the path decoder, asserted for exactly the issue cycle
- addr_seg  out  SEG_BITS  selected path index, valid while decode_en_blk = 1, else 0
- rd_vld  out  1  BRAM data valid for the tagged path
- rd_seg  out  SEG_BITS  path tag of the returning data
- inflight  out  NP  bit i = a read for path i is outstanding
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on DRAIN -> IDLE

Behaviour:
- Reset (rst_b = 0 at a clk edge):
  - state = IDLE; decode_en_blk, addr_seg, rd_vld, rd_seg, inflight, busy and done all 0.
  - Round-robin pointer = 0; latency pipeline cleared. Reset mid-operation discards all in-flight reads, and no rd_vld is produced for them.
- FSM:
  - IDLE: start -> RUN; stop is ignored.
  - RUN: stop -> DRAIN; start is ignored.
  - DRAIN: no new issue; when inflight == 0 and the pipeline is empty -> IDLE with done = 1 for one cycle. start and stop are ignored.
- Eligibility: elig = req & ~inflight. An issue occurs in a cycle iff state == RUN, stall == 0, elig != 0, and no stop that cycle.
- Arbitration:
  - Round-robin: grant the lowest index >= ptr among elig bits, else wrap to the lowest set bit.
  - After a grant g, ptr = (g + 1) mod NP.
  - ptr does not advance in cycles without an issue.
- Issue timing: decode_en_blk and addr_seg are registered outputs, asserted the cycle after the grant decision. inflight[g] sets in the same cycle decode_en_blk rises.
- Latency pipeline:
  - A RD_LAT-deep shift register of {vld, seg} is loaded at the issue cycle.
  - rd_vld and rd_seg appear exactly RD_LAT cycles after decode_en_blk.
  - inflight[rd_seg] clears in the rd_vld cycle, so that path is eligible for a grant the same cycle and can issue again the next cycle.
- Throughput: one issue per cycle maximum, back-to-back across different paths.
- stall: blocks issue only. The pipeline keeps shifting, and returns still occur and clear inflight.
- Simultaneous events:
  - A return for path i and an eligibility check of path i in the same cycle: the return wins, so i is eligible.
  - stop together with a would-be issue: no issue.
  - stop with a pipeline that is already empty: DRAIN lasts one cycle, then IDLE with done.
- A req deassert after grant has no effect on a read already issued.

Decomposition:
- Shared package: SEG_BITS, NP, RD_LAT defaults; state enum {IDLE, RUN, DRAIN}; struct rd_tag_t {vld, seg}.
- One sub-module: rr_arbiter_np (NP-wide round-robin arbiter with pointer, inputs elig and adv, outputs grant_vld and grant_idx).
- FSM and latency pipeline live in the top.

Test Plan:
- Reset mid-RUN with 2 reads in flight -> the next cycle all outputs are 0, and no rd_vld appears afterwards.
- start; req = 16'h0001 held -> decode_en_blk with addr_seg = 0 once; rd_vld/rd_seg = 0 RD_LAT (2) cycles later; reissue 1 cycle after the return; steady rate 1 issue per 3 cycles.
- start; req = 16'hFFFF held -> addr_seg sequence 0,1,2,...,15, one per cycle. Path 0 returned at cycle 2, so the sequence wraps back to 0 at the 17th issue.
- req = 16'h8009, ptr = 4 -> grants in order 15, 0, 3.
- stall = 1 for 5 cycles with 2 reads in flight -> no decode_en_blk; both rd_vld still arrive on time and inflight returns to 0.
- stop while 2 reads are in flight -> no new issue; done pulses the cycle after the last rd_vld; busy = 0 thereafter.
